// File: rtl/vga_draw_pkg.sv
// vga_draw_pkg: screen constants, pixel/coordinate types, the sprite-update
// FSM encoding and the single-axis move helper shared by the sprite drawer.
package vga_draw_pkg;

  localparam int PIXELS_HORIZ = 640;
  localparam int PIXELS_VERT  = 480;

  typedef logic [11:0] rgb_t;    // RGB444, red in [11:8]
  typedef logic [9:0]  coord_t;  // screen column / row

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_UPDATE = 1'b1;

  // Moves one axis by step. The 11-bit sum exposes a borrow below 0 (bit 10
  // set) or a result past max_pos, which then wraps or saturates.
  // Opposing buttons cancel.
  function automatic coord_t move_axis(coord_t pos, logic dec, logic inc,
                                       logic [3:0] step, coord_t max_pos,
                                       logic wrap);
    logic [10:0] sum;
    logic [10:0] lim;
    lim = {1'b0, max_pos};
    sum = {1'b0, pos};
    if (dec && !inc) begin
      sum = {1'b0, pos} - {7'd0, step};
      if (sum[10]) sum = wrap ? lim : 11'd0;
    end else if (inc && !dec) begin
      sum = {1'b0, pos} + {7'd0, step};
      if (sum > lim) sum = wrap ? 11'd0 : lim;
    end
    return sum[9:0];
  endfunction

endpackage

// File: rtl/vga_button_debounce.sv
// vga_button_debounce: 2-flop synchroniser for one asynchronous button.
// With VGA_SPRITE_DEBOUNCE_EN defined, a debouncer follows the synchroniser:
// the output level flips only after the synchronised input has disagreed
// with it for DEBOUNCE_CYC consecutive cycles.
module vga_button_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_out
);

  logic [1:0] sync_q, sync_d;

  // Shift the raw pin through two flops; sync_q[1] is safe to use
  always_comb sync_d = {sync_q[0], btn_in};

  // Synchroniser flops
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

`ifdef VGA_SPRITE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;

  // Count consecutive disagreeing cycles; any agreement restarts the count
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) lvl_d = sync_q[1];
      else                                   cnt_d = cnt_q + 1'b1;
    end
  end

  // Debouncer state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign btn_out = lvl_q;
`else
  assign btn_out = sync_q[1];
`endif

endmodule

// File: rtl/vga_sprite_mover.sv
// vga_sprite_mover: overlays NUM_SPRITES solid rectangles on the background
// colour stream (1-cycle registered pixel path), moves each sprite once per
// frame from its latched buttons (wrap or clamp at the edges) and reports
// whether the previous frame contained a sprite overlap.
// Optional button debouncing: define VGA_SPRITE_DEBOUNCE_EN.
module vga_sprite_mover #(
  parameter int PIXELS_HORIZ = vga_draw_pkg::PIXELS_HORIZ,
  parameter int PIXELS_VERT  = vga_draw_pkg::PIXELS_VERT,
  parameter int NUM_SPRITES  = 2,
  parameter int SPR_W        = 30,
  parameter int SPR_H        = 60,
  parameter int STEP         = 1,
  parameter int WRAP_MODE    = 1,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic                      Master_Clock_In,
  input  logic                      Reset_In,
  input  logic                      Disp_Ena_In,
  input  logic [9:0]                Val_Col_In,
  input  logic [9:0]                Val_Row_In,
  input  logic [NUM_SPRITES-1:0]    Up_In,
  input  logic [NUM_SPRITES-1:0]    Down_In,
  input  logic [NUM_SPRITES-1:0]    Left_In,
  input  logic [NUM_SPRITES-1:0]    Right_In,
  input  logic [12*NUM_SPRITES-1:0] Sprite_Colour_In,
  input  logic [11:0]               Bg_Colour_In,
  output logic [3:0]                Red,
  output logic [3:0]                Green,
  output logic [3:0]                Blue,
  output logic                      Frame_Tick_Out,
  output logic                      Collision_Out
);
  import vga_draw_pkg::rgb_t;
  import vga_draw_pkg::coord_t;
  import vga_draw_pkg::ST_IDLE;
  import vga_draw_pkg::ST_UPDATE;
  import vga_draw_pkg::move_axis;

  localparam coord_t XMAX  = coord_t'(PIXELS_HORIZ - SPR_W);
  localparam coord_t YMAX  = coord_t'(PIXELS_VERT - SPR_H);
  localparam coord_t Y_RST = coord_t'((PIXELS_VERT - SPR_H) / 2);
  localparam int     IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  // Synchronised (optionally debounced) buttons
  logic [NUM_SPRITES-1:0] up_s, dn_s, lf_s, rt_s;

  vga_button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up [NUM_SPRITES-1:0] (
    .clk(Master_Clock_In), .rst(Reset_In), .btn_in(Up_In), .btn_out(up_s));
  vga_button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dn [NUM_SPRITES-1:0] (
    .clk(Master_Clock_In), .rst(Reset_In), .btn_in(Down_In), .btn_out(dn_s));
  vga_button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_lf [NUM_SPRITES-1:0] (
    .clk(Master_Clock_In), .rst(Reset_In), .btn_in(Left_In), .btn_out(lf_s));
  vga_button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_rt [NUM_SPRITES-1:0] (
    .clk(Master_Clock_In), .rst(Reset_In), .btn_in(Right_In), .btn_out(rt_s));

  logic [0:0]                   state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  coord_t [NUM_SPRITES-1:0]     x_q, x_d, y_q, y_d;
  logic [NUM_SPRITES-1:0]       up_l_q, up_l_d, dn_l_q, dn_l_d;
  logic [NUM_SPRITES-1:0]       lf_l_q, lf_l_d, rt_l_q, rt_l_d;
  logic                         tick_q, tick_d, coll_q, coll_d, ovl_q, ovl_d;
  rgb_t                         rgb_q, rgb_d;

  logic active, hit_any, multi, frame_go;
  rgb_t spr_rgb;

  // Pixel path: walk sprites high to low so the lowest index ends up winning
  always_comb begin
    active  = Disp_Ena_In && ({1'b0, Val_Col_In} < 11'(PIXELS_HORIZ)) &&
              ({1'b0, Val_Row_In} < 11'(PIXELS_VERT));
    hit_any = 1'b0;
    multi   = 1'b0;
    spr_rgb = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if ({1'b0, Val_Col_In} >= {1'b0, x_q[i]} &&
          {1'b0, Val_Col_In} <  {1'b0, x_q[i]} + 11'(SPR_W) &&
          {1'b0, Val_Row_In} >= {1'b0, y_q[i]} &&
          {1'b0, Val_Row_In} <  {1'b0, y_q[i]} + 11'(SPR_H)) begin
        if (hit_any) multi = 1'b1;
        hit_any = 1'b1;
        spr_rgb = Sprite_Colour_In[12*i +: 12];
      end
    end
    if (!active)     rgb_d = '0;
    else if (hit_any) rgb_d = spr_rgb;
    else             rgb_d = Bg_Colour_In;
  end

  // Frame end only counts while idle; one seen mid-update is dropped
  assign frame_go = Disp_Ena_In && (state_q == ST_IDLE) &&
                    (Val_Col_In == 10'(PIXELS_HORIZ - 1)) &&
                    (Val_Row_In == 10'(PIXELS_VERT - 1));

  // Frame bookkeeping and the one-sprite-per-cycle position update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    up_l_d  = up_l_q;
    dn_l_d  = dn_l_q;
    lf_l_d  = lf_l_q;
    rt_l_d  = rt_l_q;
    tick_d  = frame_go;
    coll_d  = coll_q;
    ovl_d   = ovl_q | (active & multi);
    if (frame_go) begin
      up_l_d  = up_s;
      dn_l_d  = dn_s;
      lf_l_d  = lf_s;
      rt_l_d  = rt_s;
      coll_d  = ovl_d;   // includes the frame's final pixel
      ovl_d   = 1'b0;
      state_d = ST_UPDATE;
      idx_d   = '0;
    end
    if (state_q == ST_UPDATE) begin
      x_d[idx_q] = move_axis(x_q[idx_q], lf_l_q[idx_q], rt_l_q[idx_q],
                             4'(STEP), XMAX, 1'(WRAP_MODE));
      y_d[idx_q] = move_axis(y_q[idx_q], up_l_q[idx_q], dn_l_q[idx_q],
                             4'(STEP), YMAX, 1'(WRAP_MODE));
      if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // State registers; reset also aborts an in-flight update
  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      up_l_q  <= '0;
      dn_l_q  <= '0;
      lf_l_q  <= '0;
      rt_l_q  <= '0;
      tick_q  <= 1'b0;
      coll_q  <= 1'b0;
      ovl_q   <= 1'b0;
      rgb_q   <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i] <= coord_t'(i * 2 * SPR_W);
        y_q[i] <= Y_RST;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      up_l_q  <= up_l_d;
      dn_l_q  <= dn_l_d;
      lf_l_q  <= lf_l_d;
      rt_l_q  <= rt_l_d;
      tick_q  <= tick_d;
      coll_q  <= coll_d;
      ovl_q   <= ovl_d;
      rgb_q   <= rgb_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign Red            = rgb_q[11:8];
  assign Green          = rgb_q[7:4];
  assign Blue           = rgb_q[3:0];
  assign Frame_Tick_Out = tick_q;
  assign Collision_Out  = coll_q;

endmodule

// File: tb/tb_vga_sprite_mover.sv
// tb_vga_sprite_mover: directed bench for vga_sprite_mover. Two instances share
// stimulus: dut_w wraps at edges, dut_c clamps. Coordinates are driven directly
// (no full raster scan): single probe pixels and a single frame-end pixel.
module tb_vga_sprite_mover;
  localparam int NS     = 2;
  localparam int SETTLE = 12;
  localparam logic [11:0] BG = 12'h111;
  localparam logic [11:0] C0 = 12'hF00;
  localparam logic [11:0] C1 = 12'h0F0;

  logic clk = 1'b0;
  logic rst, ena;
  logic [9:0] col, row;
  logic [NS-1:0] up, dn, lf, rt;
  logic [3:0] r_w, g_w, b_w, r_c, g_c, b_c;
  logic tick_w, tick_c, coll_w, coll_c;
  logic [11:0] rgb_w, rgb_c;
  int n_cmp = 0;
  int n_err = 0;
  int tick_cnt = 0;

  assign rgb_w = {r_w, g_w, b_w};
  assign rgb_c = {r_c, g_c, b_c};

  always #5 clk = ~clk;
  always @(posedge clk) if (tick_w) tick_cnt <= tick_cnt + 1;

  vga_sprite_mover #(.PIXELS_HORIZ(640), .PIXELS_VERT(480), .NUM_SPRITES(NS),
    .SPR_W(30), .SPR_H(60), .STEP(1), .WRAP_MODE(1), .DEBOUNCE_CYC(4)) dut_w (
    .Master_Clock_In(clk), .Reset_In(rst), .Disp_Ena_In(ena),
    .Val_Col_In(col), .Val_Row_In(row), .Up_In(up), .Down_In(dn),
    .Left_In(lf), .Right_In(rt), .Sprite_Colour_In({C1, C0}),
    .Bg_Colour_In(BG), .Red(r_w), .Green(g_w), .Blue(b_w),
    .Frame_Tick_Out(tick_w), .Collision_Out(coll_w));

  vga_sprite_mover #(.PIXELS_HORIZ(640), .PIXELS_VERT(480), .NUM_SPRITES(NS),
    .SPR_W(30), .SPR_H(60), .STEP(1), .WRAP_MODE(0), .DEBOUNCE_CYC(4)) dut_c (
    .Master_Clock_In(clk), .Reset_In(rst), .Disp_Ena_In(ena),
    .Val_Col_In(col), .Val_Row_In(row), .Up_In(up), .Down_In(dn),
    .Left_In(lf), .Right_In(rt), .Sprite_Colour_In({C1, C0}),
    .Bg_Colour_In(BG), .Red(r_c), .Green(g_c), .Blue(b_c),
    .Frame_Tick_Out(tick_c), .Collision_Out(coll_c));

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one pixel for a cycle; the registered colour is readable on return
  task automatic probe(input int c, input int r);
    ena = 1'b1; col = 10'(c); row = 10'(r);
    @(posedge clk); #1;
    ena = 1'b0; col = '0; row = '0;
  endtask

  // One frame-end pixel followed by enough blanking for the update walk
  task automatic do_frame();
    ena = 1'b1; col = 10'd639; row = 10'd479;
    @(posedge clk); #1;
    ena = 1'b0; col = '0; row = '0;
    wait_cyc(NS + 4);
  endtask

  task automatic apply_reset();
    rst = 1'b1; up = '0; dn = '0; lf = '0; rt = '0; ena = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; up = '0; dn = '0; lf = '0; rt = '0;
    ena = 1'b1; col = 10'd0; row = 10'd210;   // covered pixel: reset must win
    wait_cyc(3);
    n_cmp++; if (rgb_w !== 12'h000) begin n_err++; $display("FAIL rst_rgb_w: got %h want 000", rgb_w); end
    n_cmp++; if (rgb_c !== 12'h000) begin n_err++; $display("FAIL rst_rgb_c: got %h want 000", rgb_c); end
    n_cmp++; if ({tick_w, coll_w} !== 2'b00) begin n_err++; $display("FAIL rst_tick_coll_w: got %b want 00", {tick_w, coll_w}); end
    n_cmp++; if ({tick_c, coll_c} !== 2'b00) begin n_err++; $display("FAIL rst_tick_coll_c: got %b want 00", {tick_c, coll_c}); end
    rst = 1'b0; ena = 1'b0; col = '0; row = '0;
    wait_cyc(2);
  endtask

  task automatic test_initial_draw();
    probe(0, 210);   n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL draw_s0_tl: got %h want %h", rgb_w, C0); end
    probe(29, 269);  n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL draw_s0_br: got %h want %h", rgb_w, C0); end
    probe(30, 210);  n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL draw_s0_right: got %h want %h", rgb_w, BG); end
    probe(0, 209);   n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL draw_s0_above: got %h want %h", rgb_w, BG); end
    probe(0, 270);   n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL draw_s0_below: got %h want %h", rgb_w, BG); end
    probe(60, 210);  n_cmp++; if (rgb_w !== C1) begin n_err++; $display("FAIL draw_s1_tl: got %h want %h", rgb_w, C1); end
    probe(89, 269);  n_cmp++; if (rgb_w !== C1) begin n_err++; $display("FAIL draw_s1_br: got %h want %h", rgb_w, C1); end
    probe(59, 240);  n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL draw_s1_left: got %h want %h", rgb_w, BG); end
    probe(90, 240);  n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL draw_s1_right: got %h want %h", rgb_w, BG); end
    probe(640, 210); n_cmp++; if (rgb_w !== 12'h000) begin n_err++; $display("FAIL draw_col_oob: got %h want 000", rgb_w); end
    ena = 1'b0; col = 10'd0; row = 10'd210;
    wait_cyc(1);     n_cmp++; if (rgb_w !== 12'h000) begin n_err++; $display("FAIL draw_ena_low: got %h want 000", rgb_w); end
  endtask

  task automatic test_latency();
    probe(0, 210);
    ena = 1'b1; col = 10'd100; row = 10'd100;
    #1;
    n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL lat_hold: got %h want %h", rgb_w, C0); end
    @(posedge clk); #1;
    ena = 1'b0;
    n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL lat_next: got %h want %h", rgb_w, BG); end
    wait_cyc(2);
  endtask

  task automatic test_frame_tick();
    ena = 1'b0; col = 10'd639; row = 10'd479;
    wait_cyc(1);
    n_cmp++; if (tick_w !== 1'b0) begin n_err++; $display("FAIL tick_no_ena: got %b want 0", tick_w); end
    ena = 1'b1;
    wait_cyc(1);
    ena = 1'b0; col = '0; row = '0;
    n_cmp++; if (tick_w !== 1'b1) begin n_err++; $display("FAIL tick_pulse: got %b want 1", tick_w); end
    n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL tick_last_px: got %h want %h", rgb_w, BG); end
    wait_cyc(1);
    n_cmp++; if (tick_w !== 1'b0) begin n_err++; $display("FAIL tick_one_cycle: got %b want 0", tick_w); end
    wait_cyc(NS + 3);
  endtask

  task automatic test_move_right();
    int t0;
    rt = 2'b01;
    wait_cyc(SETTLE);
    t0 = tick_cnt;
    repeat (3) do_frame();
    rt = '0;
    wait_cyc(SETTLE);
    n_cmp++; if (tick_cnt - t0 !== 3) begin n_err++; $display("FAIL right_ticks: got %0d want 3", tick_cnt - t0); end
    probe(3, 210);  n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL right_x3_left: got %h want %h", rgb_w, C0); end
    probe(2, 210);  n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL right_x2: got %h want %h", rgb_w, BG); end
    probe(32, 269); n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL right_x32: got %h want %h", rgb_w, C0); end
    probe(33, 269); n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL right_x33: got %h want %h", rgb_w, BG); end
  endtask

  task automatic test_up_down();
    up = 2'b01; dn = 2'b01;
    wait_cyc(SETTLE);
    repeat (2) do_frame();
    up = '0; dn = '0;
    wait_cyc(SETTLE);
    probe(3, 209); n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL updn_y209: got %h want %h", rgb_w, BG); end
    probe(3, 210); n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL updn_y210: got %h want %h", rgb_w, C0); end
    probe(3, 270); n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL updn_y270: got %h want %h", rgb_w, BG); end
    up = 2'b01;
    wait_cyc(SETTLE);
    do_frame();
    up = '0;
    wait_cyc(SETTLE);
    probe(3, 209); n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL up_y209: got %h want %h", rgb_w, C0); end
    probe(3, 269); n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL up_y269: got %h want %h", rgb_w, BG); end
  endtask

  // Sprite 0 sits at X=3..32, Y=209..268; sprite 1 starts at X=60, Y=210
  task automatic test_wrap_clamp();
    lf = 2'b10;
    wait_cyc(SETTLE);
    repeat (61) do_frame();
    lf = '0;
    wait_cyc(SETTLE);
    probe(610, 210);
    n_cmp++; if (rgb_w !== C1) begin n_err++; $display("FAIL wrap_x610: got %h want %h", rgb_w, C1); end
    probe(609, 210);
    n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL wrap_x609: got %h want %h", rgb_w, BG); end
    probe(0, 210);
    n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL wrap_x0: got %h want %h", rgb_w, BG); end
    n_cmp++; if (rgb_c !== C1) begin n_err++; $display("FAIL clamp_x0: got %h want %h", rgb_c, C1); end
    probe(29, 210);
    n_cmp++; if (rgb_c !== C0) begin n_err++; $display("FAIL clamp_prio: got %h want %h", rgb_c, C0); end
    probe(639, 210);
    n_cmp++; if (rgb_c !== BG) begin n_err++; $display("FAIL clamp_x639: got %h want %h", rgb_c, BG); end
    rt = 2'b10;
    wait_cyc(SETTLE);
    do_frame();
    rt = '0;
    wait_cyc(SETTLE);
    probe(0, 210);
    n_cmp++; if (rgb_w !== C1) begin n_err++; $display("FAIL wrap_inc_x0: got %h want %h", rgb_w, C1); end
    n_cmp++; if (rgb_c !== BG) begin n_err++; $display("FAIL clamp_inc_x0: got %h want %h", rgb_c, BG); end
    probe(1, 210);
    n_cmp++; if (rgb_c !== C1) begin n_err++; $display("FAIL clamp_inc_x1: got %h want %h", rgb_c, C1); end
    apply_reset();
  endtask

  task automatic test_collision();
    lf = 2'b10;
    wait_cyc(SETTLE);
    repeat (40) do_frame();
    lf = '0;
    wait_cyc(SETTLE);
    n_cmp++; if (coll_w !== 1'b0) begin n_err++; $display("FAIL coll_before: got %b want 0", coll_w); end
    probe(25, 240); n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL coll_prio: got %h want %h", rgb_w, C0); end
    probe(30, 240); n_cmp++; if (rgb_w !== C1) begin n_err++; $display("FAIL coll_s1_x30: got %h want %h", rgb_w, C1); end
    probe(19, 240); n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL coll_s0_x19: got %h want %h", rgb_w, C0); end
    n_cmp++; if (coll_w !== 1'b0) begin n_err++; $display("FAIL coll_midframe: got %b want 0", coll_w); end
    do_frame();
    n_cmp++; if (coll_w !== 1'b1) begin n_err++; $display("FAIL coll_set: got %b want 1", coll_w); end
    rt = 2'b10;
    wait_cyc(SETTLE);
    repeat (11) do_frame();
    rt = '0;
    wait_cyc(SETTLE);
    probe(29, 240); n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL sep_x29: got %h want %h", rgb_w, C0); end
    probe(30, 240); n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL sep_x30: got %h want %h", rgb_w, BG); end
    probe(31, 240); n_cmp++; if (rgb_w !== C1) begin n_err++; $display("FAIL sep_x31: got %h want %h", rgb_w, C1); end
    do_frame();
    n_cmp++; if (coll_w !== 1'b0) begin n_err++; $display("FAIL coll_clear: got %b want 0", coll_w); end
  endtask

  // Sprite 0 at X=0, sprite 1 at X=31 on entry
  task automatic test_reset_mid_update();
    rt = 2'b01;
    wait_cyc(SETTLE);
    ena = 1'b1; col = 10'd639; row = 10'd479;
    wait_cyc(1);            // tick cycle: FSM now in UPDATE, idx 0
    ena = 1'b0; col = '0; row = '0;
    wait_cyc(1);            // sprite 0 moved to X=1, idx 1
    rst = 1'b1; rt = '0;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(SETTLE);
    probe(0, 210);  n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL rmu_s0_x0: got %h want %h", rgb_w, C0); end
    probe(60, 210); n_cmp++; if (rgb_w !== C1) begin n_err++; $display("FAIL rmu_s1_x60: got %h want %h", rgb_w, C1); end
    probe(59, 210); n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL rmu_s1_x59: got %h want %h", rgb_w, BG); end
    rt = 2'b01;
    wait_cyc(SETTLE);
    do_frame();
    rt = '0;
    wait_cyc(SETTLE);
    probe(0, 210);  n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL rmu_after_x0: got %h want %h", rgb_w, BG); end
    probe(30, 210); n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL rmu_after_x30: got %h want %h", rgb_w, C0); end
    probe(31, 210); n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL rmu_after_x31: got %h want %h", rgb_w, BG); end
  endtask

`ifdef VGA_SPRITE_DEBOUNCE_EN
  task automatic test_debounce();
    apply_reset();
    rt = 2'b01;
    wait_cyc(3);
    rt = '0;
    wait_cyc(SETTLE);
    do_frame();
    probe(0, 210); n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL deb_glitch: got %h want %h", rgb_w, C0); end
    rt = 2'b01;
    wait_cyc(10);
    do_frame();
    rt = '0;
    wait_cyc(SETTLE);
    probe(0, 210); n_cmp++; if (rgb_w !== BG) begin n_err++; $display("FAIL deb_hold_x0: got %h want %h", rgb_w, BG); end
    probe(1, 210); n_cmp++; if (rgb_w !== C0) begin n_err++; $display("FAIL deb_hold_x1: got %h want %h", rgb_w, C0); end
  endtask
`endif

  initial begin
    rst = 1'b1; ena = 1'b0; col = '0; row = '0;
    up = '0; dn = '0; lf = '0; rt = '0;
    test_reset();
    test_initial_draw();
    test_latency();
    test_frame_tick();
    test_move_right();
    test_up_down();
    test_wrap_clamp();
    test_collision();
    test_reset_mid_update();
`ifdef VGA_SPRITE_DEBOUNCE_EN
    test_debounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
